audio_fifo_wr_arb: RTL and testbench

AUDIO_FIFO_WR_ARB -- requirements
Module: audio_fifo_wr_arb

---
 rtl/audio_fifo_wr_arb.sv | 97 +++++++++
 tb/tb_audio_fifo_wr_arb.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/audio_fifo_wr_arb.sv
// Four-requester round-robin burst arbiter feeding an audio prefetch FIFO write port.
// Optional macro AUDIO_FIFO_ARB_ABORT_EN: a valid gap from the granted requester ends its burst early.
module audio_fifo_wr_arb #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned BURST_LEN  = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [3:0]              req_valid,
  input  logic [4*DATA_WIDTH-1:0] req_data,
  output logic [3:0]              req_ready,
  output logic [DATA_WIDTH-1:0]   fifo_wr_data,
  output logic                    fifo_wr_en,
  input  logic                    fifo_wr_vld,
  output logic [3:0]              gnt,
  output logic                    busy
);

  localparam int unsigned CW = $clog2(BURST_LEN + 1);

  typedef enum logic {
    IDLE,
    BURST
  } state_t;

  state_t          state_q;
  logic [3:0]      gnt_q;
  logic            busy_q;
  logic [1:0]      last_ptr_q;
  logic [CW-1:0]   cnt_q;
  logic [1:0]      pick_d;
  logic            last_beat;

  // Scan from farthest to nearest so the requester closest after last_ptr wins.
  always_comb begin
    logic [1:0] cand;
    pick_d = last_ptr_q;
    cand   = last_ptr_q;
    for (int unsigned i = 4; i >= 1; i--) begin
      cand = last_ptr_q + 2'(i);
      if (req_valid[cand]) pick_d = cand;
    end
  end

  // While busy, last_ptr_q is the index of the current grant.
  assign fifo_wr_en   = busy_q & req_valid[last_ptr_q] & fifo_wr_vld;
  assign req_ready    = gnt_q & {4{fifo_wr_vld}};
  assign fifo_wr_data = busy_q ? req_data[32'(last_ptr_q)*DATA_WIDTH +: DATA_WIDTH] : '0;
  assign gnt          = gnt_q;
  assign busy         = busy_q;
  assign last_beat    = (cnt_q == CW'(BURST_LEN - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      gnt_q      <= '0;
      busy_q     <= 1'b0;
      last_ptr_q <= 2'd3;
      cnt_q      <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (|req_valid) begin
            state_q    <= BURST;
            busy_q     <= 1'b1;
            gnt_q      <= 4'b0001 << pick_d;
            last_ptr_q <= pick_d;
            cnt_q      <= '0;
          end
        end
        BURST: begin
          if (fifo_wr_en) begin
            cnt_q <= cnt_q + 1'b1;
            if (last_beat) begin
              state_q <= IDLE;
              busy_q  <= 1'b0;
              gnt_q   <= '0;
            end
          end
`ifdef AUDIO_FIFO_ARB_ABORT_EN
          else if (!req_valid[last_ptr_q] && fifo_wr_vld) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            gnt_q   <= '0;
          end
`endif
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          gnt_q   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_audio_fifo_wr_arb.sv
// Directed bench for audio_fifo_wr_arb: per-cycle grant/handshake checks plus a
// scoreboard of tagged {requester, sequence} words expected on the FIFO write port.
module tb_audio_fifo_wr_arb;

  localparam int unsigned DW = 16;

  logic          clk;
  logic          rst_n;
  logic [3:0]    req_valid;
  logic [4*DW-1:0] req_data;
  logic [3:0]    req_ready;
  logic [DW-1:0] fifo_wr_data;
  logic          fifo_wr_en;
  logic          fifo_wr_vld;
  logic [3:0]    gnt;
  logic          busy;

  int checks = 0;
  int errors = 0;

  logic [11:0]   seq     [4];
  logic [11:0]   exp_seq [4];
  logic [DW-1:0] sb [$];

  audio_fifo_wr_arb #(
    .DATA_WIDTH(DW),
    .BURST_LEN (16)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid   (req_valid),
    .req_data    (req_data),
    .req_ready   (req_ready),
    .fifo_wr_data(fifo_wr_data),
    .fifo_wr_en  (fifo_wr_en),
    .fifo_wr_vld (fifo_wr_vld),
    .gnt         (gnt),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic push_burst(input int r, input int n);
    for (int k = 0; k < n; k++) begin
      sb.push_back({4'(r), exp_seq[r]});
      exp_seq[r] = exp_seq[r] + 12'd1;
    end
  endtask

  // One clock: drive at negedge, sample 1 time unit later, count handshakes.
  task automatic cyc(input logic rst, input logic [3:0] v, input logic wv,
                     input logic [3:0] eg, input logic een);
    logic [DW-1:0] exp_w;
    @(negedge clk);
    rst_n       = rst;
    req_valid   = v;
    fifo_wr_vld = wv;
    for (int i = 0; i < 4; i++) req_data[i*DW +: DW] = {4'(i), seq[i]};
    #1;
    chk("gnt",   32'(gnt),        32'(eg));
    chk("busy",  32'(busy),       32'(|eg));
    chk("wr_en", 32'(fifo_wr_en), 32'(een));
    chk("ready", 32'(req_ready),  32'(eg & {4{wv}}));
    if (eg == 4'b0000) chk("data_idle", 32'(fifo_wr_data), 32'(0));
    if (fifo_wr_en) begin
      chk("sb_nonempty", 32'(sb.size() != 0), 32'(1));
      if (sb.size() != 0) begin
        exp_w = sb.pop_front();
        chk("wr_data", 32'(fifo_wr_data), 32'(exp_w));
      end
    end
    for (int i = 0; i < 4; i++)
      if (req_valid[i] && req_ready[i]) seq[i] = seq[i] + 12'd1;
  endtask

  task automatic rep(input int n, input logic rst, input logic [3:0] v, input logic wv,
                     input logic [3:0] eg, input logic een);
    for (int k = 0; k < n; k++) cyc(rst, v, wv, eg, een);
  endtask

  task automatic sb_drained(input string tag);
    chk(tag, 32'(sb.size()), 32'(0));
  endtask

  initial begin
    rst_n       = 1'b0;
    req_valid   = '0;
    req_data    = '0;
    fifo_wr_vld = 1'b1;
    for (int i = 0; i < 4; i++) begin
      seq[i]     = '0;
      exp_seq[i] = '0;
    end

    // Reset holds everything idle even with all requesters valid, then idle with no requests.
    rep(2, 1'b0, 4'b1111, 1'b1, 4'b0000, 1'b0);
    rep(2, 1'b1, 4'b0000, 1'b1, 4'b0000, 1'b0);

    // Single requester: arbitration cycle, 16 beats, one idle cycle, 16 more beats.
    push_burst(0, 32);
    cyc(1'b1, 4'b0001, 1'b1, 4'b0000, 1'b0);
    rep(16, 1'b1, 4'b0001, 1'b1, 4'b0001, 1'b1);
    cyc(1'b1, 4'b0001, 1'b1, 4'b0000, 1'b0);
    rep(16, 1'b1, 4'b0001, 1'b1, 4'b0001, 1'b1);
    rep(2, 1'b1, 4'b0000, 1'b1, 4'b0000, 1'b0);
    sb_drained("sb_single");

    // All valid from reset: grant order 0,1,2,3,0 with 17-cycle period.
    cyc(1'b0, 4'b0000, 1'b1, 4'b0000, 1'b0);
    for (int r = 0; r < 5; r++) begin
      push_burst(r % 4, 16);
      cyc(1'b1, 4'b1111, 1'b1, 4'b0000, 1'b0);
      rep(16, 1'b1, 4'b1111, 1'b1, 4'b0001 << (r % 4), 1'b1);
    end
    cyc(1'b1, 4'b0000, 1'b1, 4'b0000, 1'b0);
    sb_drained("sb_rr");

    // Requester 2 with FIFO full for beats 5..9.
    push_burst(2, 16);
    cyc(1'b1, 4'b0100, 1'b1, 4'b0000, 1'b0);
    rep(4,  1'b1, 4'b0100, 1'b1, 4'b0100, 1'b1);
    rep(5,  1'b1, 4'b0100, 1'b0, 4'b0100, 1'b0);
    rep(12, 1'b1, 4'b0100, 1'b1, 4'b0100, 1'b1);
    cyc(1'b1, 4'b0000, 1'b1, 4'b0000, 1'b0);
    sb_drained("sb_stall");

    // Requester 1 drops valid after beat 4 for 3 cycles; requester 2 waiting.
`ifdef AUDIO_FIFO_ARB_ABORT_EN
    push_burst(1, 4);
    push_burst(2, 16);
    cyc(1'b1, 4'b0110, 1'b1, 4'b0000, 1'b0);
    rep(4,  1'b1, 4'b0110, 1'b1, 4'b0010, 1'b1);
    cyc(1'b1, 4'b0100, 1'b1, 4'b0010, 1'b0);
    cyc(1'b1, 4'b0100, 1'b1, 4'b0000, 1'b0);
    rep(16, 1'b1, 4'b0100, 1'b1, 4'b0100, 1'b1);
`else
    push_burst(1, 16);
    push_burst(2, 16);
    cyc(1'b1, 4'b0110, 1'b1, 4'b0000, 1'b0);
    rep(4,  1'b1, 4'b0110, 1'b1, 4'b0010, 1'b1);
    rep(3,  1'b1, 4'b0100, 1'b1, 4'b0010, 1'b0);
    rep(12, 1'b1, 4'b0110, 1'b1, 4'b0010, 1'b1);
    cyc(1'b1, 4'b0110, 1'b1, 4'b0000, 1'b0);
    rep(16, 1'b1, 4'b0110, 1'b1, 4'b0100, 1'b1);
`endif
    cyc(1'b1, 4'b0000, 1'b1, 4'b0000, 1'b0);
    sb_drained("sb_gap");

    // Reset at beat 7 of a requester-0 burst, then requester 3 alone.
    push_burst(0, 6);
    cyc(1'b1, 4'b0001, 1'b1, 4'b0000, 1'b0);
    rep(6, 1'b1, 4'b0001, 1'b1, 4'b0001, 1'b1);
    rep(2, 1'b0, 4'b0001, 1'b1, 4'b0000, 1'b0);
    sb_drained("sb_abandon");
    push_burst(3, 16);
    cyc(1'b1, 4'b1000, 1'b1, 4'b0000, 1'b0);
    rep(16, 1'b1, 4'b1000, 1'b1, 4'b1000, 1'b1);
    cyc(1'b1, 4'b0000, 1'b1, 4'b0000, 1'b0);
    sb_drained("sb_post_reset");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
